// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared defaults and FSM encoding for the shared-adder arbiter
package add_arb_pkg;

  localparam int ADD_WIDTH = 32;
  localparam int ADD_NREQ  = 4;
  localparam int ADD_IDW   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rc_adder32.sv
// rtl/rc_adder32.sv - ripple-carry adder with carry-in tied low, carry-out and signed overflow
module rc_adder32
  import add_arb_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic carry;
  logic carry_msb;

  // carry_msb is the carry into the top bit; xor with the final carry gives signed overflow
  always_comb begin
    carry     = 1'b0;
    carry_msb = 1'b0;
    sum       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) begin
        carry_msb = carry;
      end
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
    ovf  = carry ^ carry_msb;
  end

endmodule

// File: rtl/add_share_arb.sv
// rtl/add_share_arb.sv - round-robin arbiter sharing one adder among NREQ requesters
module add_share_arb
  import add_arb_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int NREQ  = ADD_NREQ,
  parameter int IDW   = ADD_IDW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic                  busy
);

  state_t           state, next_state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic             grant_found;
  logic [IDW:0]     cand;
  logic [IDW-1:0]   op_id;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout, add_ovf;
  logic             accept;
  logic [IDW-1:0]   ptr_next;

  // Search upward from rr_ptr, wrapping at NREQ; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == IDW'(k)) begin
        sel_a = req_a[k*WIDTH +: WIDTH];
        sel_b = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_next = (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (grant_found && !reset) begin
          accept     = 1'b1;
          req_ready  = NREQ'(1) << grant_id;
          next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        next_state = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Response registers load only in EXEC, so they hold while RESP is back-pressured.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      op_id    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        op_id <= grant_id;
        op_a  <= sel_a;
        op_b  <= sel_b;
      end
      if (state == ST_EXEC) begin
        rsp_id   <= op_id;
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
        rsp_ovf  <= add_ovf;
      end
      if (state == ST_RESP && rsp_ready) begin
        rr_ptr <= ptr_next;
      end
    end
  end

  rc_adder32 #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a    (op_a),
    .b    (op_b),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

endmodule

// File: tb/tb_add_share_arb.sv
// tb/tb_add_share_arb.sv - self-checking bench for add_share_arb with a round-robin/adder reference model
module tb_add_share_arb;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;
  logic         busy;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_ptr = 0;

  always #5 clk = ~clk;

  add_share_arb #(.WIDTH(32), .NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  // Reference: grant is the first set mask bit at or after ptr, wrapping.
  function automatic int rr_pick(logic [3:0] mask, int ptr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Reference: {ovf, cout, sum} from 33-bit arithmetic and operand/result sign rule.
  function automatic logic [33:0] ref_add(logic [31:0] a, logic [31:0] b);
    logic [32:0] w;
    logic        v;
    w = {1'b0, a} + {1'b0, b};
    v = (a[31] == b[31]) && (w[31] != a[31]);
    return {v, w[32], w[31:0]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ptr = 0;
  endtask

  // One transaction from IDLE: present mask, record grant, measure latency, stall, then release.
  task automatic xact(input logic [3:0] mask, input logic [127:0] a, input logic [127:0] b,
                      input int stall, output logic [3:0] rdy, output int lat,
                      output logic [1:0] rid, output logic [31:0] s, output logic c,
                      output logic o, output bit stable);
    @(posedge clk); #1;
    req_valid = mask; req_a = a; req_b = b; rsp_ready = 1'b0;
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk); #1;
    req_valid = '0;
    lat = 1;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    rid = rsp_id; s = rsp_sum; c = rsp_cout; o = rsp_ovf; stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      req_valid = 4'hF;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== rid || rsp_sum !== s || rsp_cout !== c ||
          rsp_ovf !== o || req_ready !== 4'b0000 || busy !== 1'b1) stable = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if ({rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== 36'd0) begin
      n_fail++; $display("FAIL reset_rsp_fields: got id=%0d sum=%h c=%b o=%b expected all zero", rsp_id, rsp_sum, rsp_cout, rsp_ovf);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL idle_no_req: got busy=%b ready=%b expected busy=0 ready=0000", busy, req_ready);
    end
    exp_ptr = 0;
  endtask

  task automatic test_basic();
    logic [127:0] a, b;
    logic [3:0] rdy; int lat; logic [1:0] rid; logic [31:0] s; logic c, o; bit st;
    a = rand128(); b = rand128();
    a[31:0] = 32'h0000_0001; b[31:0] = 32'h0000_0002;
    xact(4'b0001, a, b, 0, rdy, lat, rid, s, c, o, st);
    n_cmp++; if (rdy !== 4'b0001) begin n_fail++; $display("FAIL basic_grant: got %b expected 0001", rdy); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected 2", lat); end
    n_cmp++; if (rid !== 2'd0) begin n_fail++; $display("FAIL basic_id: got %0d expected 0", rid); end
    n_cmp++; if ({o, c, s} !== {1'b0, 1'b0, 32'h0000_0003}) begin
      n_fail++; $display("FAIL basic_result: got sum=%h c=%b o=%b expected sum=00000003 c=0 o=0", s, c, o);
    end
    exp_ptr = 1;
  endtask

  task automatic test_flags();
    logic [31:0] fa [3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] fb [3] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
    logic [31:0] fs [3] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    logic        fc [3] = '{1'b0, 1'b1, 1'b1};
    logic        fo [3] = '{1'b1, 1'b0, 1'b1};
    logic [127:0] a, b;
    logic [3:0] rdy; int lat; logic [1:0] rid; logic [31:0] s; logic c, o; bit st;
    for (int i = 0; i < 3; i++) begin
      a = rand128(); b = rand128();
      a[(i+1)*32 +: 32] = fa[i]; b[(i+1)*32 +: 32] = fb[i];
      xact(4'b0001 << (i + 1), a, b, 0, rdy, lat, rid, s, c, o, st);
      n_cmp++; if (rid !== 2'(i + 1)) begin n_fail++; $display("FAIL flags_id[%0d]: got %0d expected %0d", i, rid, i + 1); end
      n_cmp++; if (s !== fs[i] || c !== fc[i] || o !== fo[i]) begin
        n_fail++; $display("FAIL flags_result[%0d]: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b", i, s, c, o, fs[i], fc[i], fo[i]);
      end
      exp_ptr = (i + 2) % 4;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b; logic [33:0] r;
    logic [3:0] rdy; int lat; logic [1:0] rid; logic [31:0] s; logic c, o; bit st;
    a = rand128(); b = rand128();
    r = ref_add(a[63:32], b[63:32]);
    xact(4'b0010, a, b, 5, rdy, lat, rid, s, c, o, st);
    n_cmp++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b expected 1", st); end
    n_cmp++; if ({o, c, s} !== r || rid !== 2'd1) begin
      n_fail++; $display("FAIL bp_result: got id=%0d %h expected id=1 %h", rid, {o, c, s}, r);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
    end
    exp_ptr = 2;
  endtask

  task automatic test_round_robin();
    logic [127:0] a, b; logic [33:0] r;
    int ids [5]; int at [5]; int cnt; int cyc;
    do_reset();
    a = rand128(); b = rand128();
    @(posedge clk); #1;
    req_valid = 4'hF; req_a = a; req_b = b; rsp_ready = 1'b1;
    cnt = 0; cyc = 0;
    while (cnt < 5 && cyc < 40) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ids[cnt] = int'(rsp_id); at[cnt] = cyc;
        r = ref_add(a[rsp_id*32 +: 32], b[rsp_id*32 +: 32]);
        n_cmp++; if ({rsp_ovf, rsp_cout, rsp_sum} !== r) begin
          n_fail++; $display("FAIL rr_result[%0d]: got %h expected %h", cnt, {rsp_ovf, rsp_cout, rsp_sum}, r);
        end
        cnt++;
        if (cnt == 5) req_valid = '0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rsp_ready = 1'b0;
    n_cmp++; if (cnt !== 5) begin n_fail++; $display("FAIL rr_count: got %0d expected 5", cnt); end
    for (int i = 0; i < cnt; i++) begin
      n_cmp++; if (ids[i] !== i % 4) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d expected %0d", i, ids[i], i % 4); end
      n_cmp++; if (at[i] !== 2 + 3 * i) begin n_fail++; $display("FAIL rr_spacing[%0d]: got cycle %0d expected %0d", i, at[i], 2 + 3 * i); end
    end
    exp_ptr = 1;
  endtask

  task automatic test_reset_mid_op();
    int bad; int seen;
    @(posedge clk); #1;
    req_valid = 4'b0100; req_a = rand128(); req_b = rand128(); rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_grant: got %b expected 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_sum !== 32'd0) begin
      n_fail++; $display("FAIL mid_after_reset: got busy=%b rsp_valid=%b sum=%h expected 0 0 0", busy, rsp_valid, rsp_sum);
    end
    req_valid = 4'hF;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_zero: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    bad = 0; seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (rsp_id === 2'd2) bad++;
        else if (rsp_id === 2'd0) seen++;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL mid_no_req2_rsp: got %0d expected 0", bad); end
    n_cmp++; if (seen !== 1) begin n_fail++; $display("FAIL mid_req0_rsp: got %0d expected 1", seen); end
    exp_ptr = 1;
  endtask

  task automatic test_withdrawn();
    int bad;
    @(posedge clk); #1;
    req_valid = 4'b0001; req_a = rand128(); req_b = rand128(); rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wd_grant0: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b1000;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL wd_exec_ready: got %b expected 0000", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL wd_resp: got valid=%b id=%0d ready=%b expected 1 0 0000", rsp_valid, rsp_id, req_ready);
    end
    req_valid = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL wd_no_grant3: got %0d active cycles expected 0", bad); end
    exp_ptr = 1;
  endtask

  task automatic test_random();
    logic [127:0] a, b; logic [3:0] mask; logic [33:0] r; int g;
    logic [3:0] rdy; int lat; logic [1:0] rid; logic [31:0] s; logic c, o; bit st;
    for (int n = 0; n < 40; n++) begin
      mask = 4'($urandom_range(1, 15));
      a = rand128(); b = rand128();
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) a[k*32 +: 32] = 32'h7FFF_FFFF + 32'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) b[k*32 +: 32] = 32'h8000_0000 - 32'($urandom_range(0, 1));
      end
      g = rr_pick(mask, exp_ptr);
      r = ref_add(a[g*32 +: 32], b[g*32 +: 32]);
      xact(mask, a, b, $urandom_range(0, 3), rdy, lat, rid, s, c, o, st);
      n_cmp++; if (rdy !== (4'b0001 << g)) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %b expected %b", n, rdy, 4'b0001 << g); end
      n_cmp++; if (lat !== 2 || rid !== 2'(g)) begin
        n_fail++; $display("FAIL rnd_lat_id[%0d]: got lat=%0d id=%0d expected lat=2 id=%0d", n, lat, rid, g);
      end
      n_cmp++; if ({o, c, s} !== r) begin n_fail++; $display("FAIL rnd_result[%0d]: got %h expected %h", n, {o, c, s}, r); end
      n_cmp++; if (st !== 1'b1) begin n_fail++; $display("FAIL rnd_hold[%0d]: got %b expected 1", n, st); end
      exp_ptr = (g + 1) % 4;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_backpressure();
    test_round_robin();
    test_reset_mid_op();
    test_withdrawn();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
